// File: rtl/ikascc_wave_sequencer_if.sv
// Bus bundle for the wave sequencer: clock enable, divider control, volume, wave RAM write port and outputs.
// The master drives the controls, the slave (the sequencer) drives phase, step and sample.
interface ikascc_wave_sequencer_if;
    logic               i_MCLK_PCEN_n;
    logic               i_KEYON;
    logic [11:0]        i_FREQ;
    logic               i_FREQ_WR;
    logic               i_PHASE_RST;
    logic [3:0]         i_VOL;
    logic               i_WAV_WE;
    logic [4:0]         i_WAV_ADDR;
    logic [7:0]         i_WAV_D;
    logic [4:0]         o_PHASE;
    logic               o_STEP;
    logic signed [11:0] o_SAMPLE;

    modport master (
        output i_MCLK_PCEN_n, i_KEYON, i_FREQ, i_FREQ_WR, i_PHASE_RST,
               i_VOL, i_WAV_WE, i_WAV_ADDR, i_WAV_D,
        input  o_PHASE, o_STEP, o_SAMPLE
    );

    modport slave (
        input  i_MCLK_PCEN_n, i_KEYON, i_FREQ, i_FREQ_WR, i_PHASE_RST,
               i_VOL, i_WAV_WE, i_WAV_ADDR, i_WAV_D,
        output o_PHASE, o_STEP, o_SAMPLE
    );
endinterface

// File: rtl/ikascc_wave_sequencer.sv
// Wave sequencer: a 12-bit down-divider steps a 5-bit phase through a 32x8 wave RAM; the sample is RAM x volume.
// Optional IKASCC_FREQ_MIN_CLAMP_EN: periods below 9 keep counting but freeze the phase, like the original chip.
module ikascc_wave_sequencer (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST,
    ikascc_wave_sequencer_if.slave seq
);
    logic               tickEn;
    logic               advanceOk;
    logic [11:0]        divQ, divD;
    logic [4:0]         phQ, phD;
    logic               stepQ, stepD;
    logic [7:0]         rdQ;
    logic signed [11:0] sampleQ, sampleD;
    logic [7:0]         ramQ [32];

    assign tickEn = ~seq.i_MCLK_PCEN_n;

`ifdef IKASCC_FREQ_MIN_CLAMP_EN
    assign advanceOk = (seq.i_FREQ >= 12'd9);
`else
    assign advanceOk = 1'b1;
`endif

    // A frequency write overrides counting; otherwise an expired divider reloads and moves the phase on.
    always_comb begin
        divD  = divQ;
        phD   = phQ;
        stepD = 1'b0;
        if (seq.i_FREQ_WR) begin
            divD = seq.i_FREQ;
            if (seq.i_PHASE_RST) begin
                phD = '0;
            end
        end else if (seq.i_KEYON) begin
            if (divQ == '0) begin
                divD = seq.i_FREQ;
                if (advanceOk) begin
                    phD   = phQ + 5'd1;
                    stepD = 1'b1;
                end
            end else begin
                divD = divQ - 12'd1;
            end
        end
    end

    // Both operands widened to 12 bits; the product range fits without saturation.
    always_comb begin
        sampleD = '0;
        if (seq.i_KEYON) begin
            sampleD = $signed({{4{rdQ[7]}}, rdQ}) * $signed({8'd0, seq.i_VOL});
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            divQ    <= '0;
            phQ     <= '0;
            stepQ   <= 1'b0;
            rdQ     <= '0;
            sampleQ <= '0;
        end else if (tickEn) begin
            divQ    <= divD;
            phQ     <= phD;
            stepQ   <= stepD;
            rdQ     <= ramQ[phQ];
            sampleQ <= sampleD;
        end
    end

    // Wave RAM is deliberately outside reset; a same-tick read above sees the old word.
    always_ff @(posedge i_EMUCLK) begin
        if (tickEn && seq.i_WAV_WE) begin
            ramQ[seq.i_WAV_ADDR] <= seq.i_WAV_D;
        end
    end

    assign seq.o_PHASE  = phQ;
    assign seq.o_STEP   = stepQ;
    assign seq.o_SAMPLE = sampleQ;
endmodule

// File: tb/tb_ikascc_wave_sequencer.sv
// Bench for the wave sequencer: directed scenarios plus random traffic checked against a tick-level model.
// The model follows IKASCC_FREQ_MIN_CLAMP_EN the same way the design does.
module tb_ikascc_wave_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ikascc_wave_sequencer_if bus();

    ikascc_wave_sequencer dut (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .seq      (bus)
    );

`ifdef IKASCC_FREQ_MIN_CLAMP_EN
    localparam bit clampOn = 1'b1;
`else
    localparam bit clampOn = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    int mDiv, mPh, mRd, mSample, mStep;
    int mRam [32];
    int phHist [$];

    function automatic int s8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mDiv = 0; mPh = 0; mRd = 0; mSample = 0; mStep = 0;
    endtask

    // One enabled tick expressed directly from the behavioural rules.
    task automatic modelTick(input bit keyon, input int freq, input bit freqWr, input bit phRst,
                             input int vol, input bit we, input int addr, input int d);
        mSample = keyon ? s8(mRd) * vol : 0;
        mRd     = mRam[mPh];
        if (we) mRam[addr] = d;
        mStep = 0;
        if (freqWr) begin
            mDiv = freq;
            if (phRst) mPh = 0;
        end else if (keyon) begin
            if (mDiv == 0) begin
                mDiv = freq;
                if (!clampOn || freq >= 9) begin
                    mPh   = (mPh + 1) % 32;
                    mStep = 1;
                end
            end else begin
                mDiv = mDiv - 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit pcenN, input bit keyon, input logic [11:0] freq,
                                 input bit freqWr, input bit phRst, input logic [3:0] vol,
                                 input bit we, input logic [4:0] addr, input logic [7:0] d);
        bus.i_MCLK_PCEN_n = pcenN;
        bus.i_KEYON       = keyon;
        bus.i_FREQ        = freq;
        bus.i_FREQ_WR     = freqWr;
        bus.i_PHASE_RST   = phRst;
        bus.i_VOL         = vol;
        bus.i_WAV_WE      = we;
        bus.i_WAV_ADDR    = addr;
        bus.i_WAV_D       = d;
        @(posedge clk);
        if (!pcenN) modelTick(keyon, int'(freq), freqWr, phRst, int'(vol), we, int'(addr), int'(d));
        @(negedge clk);
        checkOutput("phase",  bus.o_PHASE,  mPh);
        checkOutput("step",   bus.o_STEP,   mStep);
        checkOutput("sample", bus.o_SAMPLE, mSample);
    endtask

    task automatic runTick(input bit keyon, input logic [11:0] freq, input logic [3:0] vol);
        applyStimulus(1'b0, keyon, freq, 1'b0, 1'b0, vol, 1'b0, 5'd0, 8'd0);
    endtask

    int lastStep;
    int stepCount;
    int oldV, newV;

    initial begin
        for (int i = 0; i < 32; i++) mRam[i] = 0;
        modelReset();
        bus.i_MCLK_PCEN_n = 1'b1;
        bus.i_KEYON = 1'b0; bus.i_FREQ = '0; bus.i_FREQ_WR = 1'b0; bus.i_PHASE_RST = 1'b0;
        bus.i_VOL = '0; bus.i_WAV_WE = 1'b0; bus.i_WAV_ADDR = '0; bus.i_WAV_D = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstPhase",  bus.o_PHASE,  0);
        checkOutput("rstStep",   bus.o_STEP,   0);
        checkOutput("rstSample", bus.o_SAMPLE, 0);
        rst = 1'b0;

        // Period test: RAM[n]=n, period 4, unity volume.
        for (int n = 0; n < 32; n++)
            applyStimulus(1'b0, 1'b0, 12'd3, 1'b0, 1'b0, 4'd1, 1'b1, 5'(n), 8'(n));
        applyStimulus(1'b0, 1'b1, 12'd3, 1'b1, 1'b1, 4'd1, 1'b0, 5'd0, 8'd0);
        lastStep = -1;
        for (int i = 0; i < 140; i++) begin
            runTick(1'b1, 12'd3, 4'd1);
            phHist.push_back(mPh);
            if (i >= 2) checkOutput("delay2", bus.o_SAMPLE, phHist[i-2]);
            if (bus.o_STEP) begin
                if (lastStep >= 0) checkOutput("period4", i - lastStep, 4);
                lastStep = i;
            end
        end
        checkOutput("wrapPhase", bus.o_PHASE, 3);

        // Scaling test: most negative and most positive words at full volume.
        applyStimulus(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 4'd0, 1'b1, 5'd0, 8'h80);
        applyStimulus(1'b0, 1'b1, 12'd200, 1'b1, 1'b1, 4'd15, 1'b0, 5'd0, 8'd0);
        runTick(1'b1, 12'd200, 4'd15);
        runTick(1'b1, 12'd200, 4'd15);
        checkOutput("scaleNeg", bus.o_SAMPLE, -1920);
        applyStimulus(1'b0, 1'b1, 12'd200, 1'b0, 1'b0, 4'd15, 1'b1, 5'd0, 8'h7F);
        runTick(1'b1, 12'd200, 4'd15);
        runTick(1'b1, 12'd200, 4'd15);
        checkOutput("scalePos", bus.o_SAMPLE, 1905);

        // Priority test: frequency write with phase reset lands on an expiring divider at phase 17.
        applyStimulus(1'b0, 1'b1, 12'd9, 1'b1, 1'b1, 4'd2, 1'b0, 5'd0, 8'd0);
        for (int i = 0; i < 400 && !(mPh == 17 && mDiv == 0); i++) runTick(1'b1, 12'd9, 4'd2);
        checkOutput("prioReach", bus.o_PHASE, 17);
        applyStimulus(1'b0, 1'b1, 12'd9, 1'b1, 1'b1, 4'd2, 1'b0, 5'd0, 8'd0);
        checkOutput("prioPhase", bus.o_PHASE, 0);
        checkOutput("prioStep",  bus.o_STEP,  0);
        for (int i = 0; i < 9; i++) runTick(1'b1, 12'd9, 4'd2);
        runTick(1'b1, 12'd9, 4'd2);
        checkOutput("prioReload", bus.o_STEP, 1);

        // Key-off and clock-enable gating.
        for (int i = 0; i < 400 && mPh != 5; i++) runTick(1'b1, 12'd9, 4'd3);
        runTick(1'b0, 12'd9, 4'd3);
        runTick(1'b0, 12'd9, 4'd3);
        checkOutput("keyHold",   bus.o_PHASE,  5);
        checkOutput("keySample", bus.o_SAMPLE, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b1, 12'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                          4'($urandom), 1'b1, 5'($urandom), 8'($urandom));
        checkOutput("pcenHold", bus.o_PHASE, 5);

        // Read-before-write hazard on the current phase address.
        oldV = s8(mRam[5]);
        newV = $urandom_range(0, 255);
        applyStimulus(1'b0, 1'b1, 12'd200, 1'b1, 1'b0, 4'd1, 1'b0, 5'd0, 8'd0);
        runTick(1'b1, 12'd200, 4'd1);
        applyStimulus(1'b0, 1'b1, 12'd200, 1'b0, 1'b0, 4'd1, 1'b1, 5'd5, 8'(newV));
        runTick(1'b1, 12'd200, 4'd1);
        checkOutput("hazOld", bus.o_SAMPLE, oldV);
        runTick(1'b1, 12'd200, 4'd1);
        checkOutput("hazNew", bus.o_SAMPLE, s8(newV));

        // Reset pulse mid-period: outputs clear at once, RAM survives, divider restarts at zero.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstPhase",  bus.o_PHASE,  0);
        checkOutput("midRstStep",   bus.o_STEP,   0);
        checkOutput("midRstSample", bus.o_SAMPLE, 0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        runTick(1'b1, 12'd200, 4'd1);
        checkOutput("rstAdvance", bus.o_PHASE, 1);
        runTick(1'b1, 12'd200, 4'd1);
        runTick(1'b1, 12'd200, 4'd1);
        checkOutput("ramKept", bus.o_SAMPLE, 1);

        // Small-period handling: period value 8.
        applyStimulus(1'b0, 1'b1, 12'd8, 1'b1, 1'b1, 4'd1, 1'b0, 5'd0, 8'd0);
        stepCount = 0;
        for (int i = 0; i < 30; i++) begin
            runTick(1'b1, 12'd8, 4'd1);
            if (bus.o_STEP) stepCount++;
        end
        checkOutput("clampSteps", stepCount, clampOn ? 0 : 3);
        checkOutput("clampPhase", bus.o_PHASE, clampOn ? 0 : 3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
                          12'($urandom_range(0, 12)), 1'($urandom_range(0, 15) == 0),
                          1'($urandom), 4'($urandom), 1'($urandom_range(0, 4) == 0),
                          5'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/ikascc_wave_sequencer.md
IKASCC_WAVE_SEQUENCER -- requirements
Module: ikascc_wave_sequencer

Interface
REQ-001 The block SHALL have a single clock, i_EMUCLK (input, 1 bit), with all state updated on its rising edge.
REQ-002 The block SHALL have reset i_RST (input, 1 bit); reset is asynchronous and active-high.
REQ-003 i_MCLK_PCEN_n (input, 1): active-low clock enable; an "enabled tick" is a rising i_EMUCLK edge with i_MCLK_PCEN_n=0.
REQ-004 i_KEYON (input, 1): channel enable; 1 means the divider runs and the sample output is live.
REQ-005 i_FREQ (input, 12): divider period value.
REQ-006 i_FREQ_WR (input, 1): frequency-write strobe.
REQ-007 i_PHASE_RST (input, 1): qualifies i_FREQ_WR to also clear the phase.
REQ-008 i_VOL (input, 4): unsigned volume.
REQ-009 i_WAV_WE (input, 1): wave RAM write enable.
REQ-010 i_WAV_ADDR (input, 5): wave RAM write address.
REQ-011 i_WAV_D (input, 8): wave RAM write data.
REQ-012 o_PHASE (output, 5): current wave address.
REQ-013 o_STEP (output, 1): one-tick pulse on each phase advance.
REQ-014 o_SAMPLE (output, 12, signed): volume-scaled sample.

Function
REQ-015 Internal state SHALL be a 12-bit down-divider DIV, a 5-bit phase PH, a 32x8 wave RAM, an 8-bit read register RD and the o_SAMPLE register; nothing SHALL change on non-enabled edges.
REQ-016 On an enabled tick with i_FREQ_WR=1, DIV SHALL load i_FREQ, and PH SHALL clear to 0 if i_PHASE_RST=1; this takes priority over counting on that tick.
REQ-017 On an enabled tick with i_FREQ_WR=0 and i_KEYON=1, DIV SHALL behave as follows: if DIV=0, it SHALL reload i_FREQ, PH SHALL increment by 1 modulo 32 (31 wraps to 0), and o_STEP SHALL be 1 for that tick; otherwise DIV SHALL decrement by 1.
REQ-018 With i_KEYON=0, DIV and PH SHALL hold, and o_STEP SHALL be 0.
REQ-019 The phase period SHALL therefore be i_FREQ+1 enabled ticks; i_FREQ=0 SHALL advance PH every tick.
REQ-020 On an enabled tick with i_WAV_WE=1, RAM[i_WAV_ADDR] SHALL take i_WAV_D, regardless of i_KEYON.
REQ-021 RD SHALL load RAM[PH] on every enabled tick (read stage 1).
REQ-022 If a write hits address PH on the same tick, RD SHALL receive the old contents (read-before-write); the new value appears one tick later.
REQ-023 o_SAMPLE SHALL load signed(RD) x unsigned(i_VOL) as a 12-bit signed product on every enabled tick (stage 2), using i_VOL as sampled at that tick.
REQ-024 Total latency from a PH change to the corresponding o_SAMPLE update SHALL be 2 enabled ticks.
REQ-025 If i_KEYON=0 at stage 2, o_SAMPLE SHALL load 0; RD continues to track RAM[PH].
REQ-026 The product range SHALL be -1920..+1905, with no saturation needed.

Reset
REQ-027 While i_RST=1, the block SHALL asynchronously hold DIV=0, PH=0, RD=0x00, o_STEP=0 and o_SAMPLE=0, irrespective of i_MCLK_PCEN_n.
REQ-028 The wave RAM SHALL NOT be reset; its contents survive i_RST.
REQ-029 Reset asserted mid-period SHALL abort the divider; after release the first enabled tick with i_KEYON=1 sees DIV=0, so PH advances to 1 immediately.

Configuration
REQ-030 The macro IKASCC_FREQ_MIN_CLAMP_EN SHALL control handling of small i_FREQ values, with the behaviour defined in REQ-031 and REQ-032.
REQ-031 When IKASCC_FREQ_MIN_CLAMP_EN is defined and i_FREQ<9, DIV SHALL still load and count, but PH SHALL NOT advance and o_STEP SHALL stay 0 (chip-accurate halt).
REQ-032 When IKASCC_FREQ_MIN_CLAMP_EN is undefined, all i_FREQ values SHALL advance PH per REQ-017.

Verification
REQ-033 Period test: write RAM[n]=n for all n, i_FREQ=3, i_KEYON=1, i_VOL=1 -> o_STEP every 4 enabled ticks, PH 0..31 then back to 0, o_SAMPLE=PH value delayed 2 ticks.
REQ-034 Scaling test: RAM[0]=0x80, RAM[1]=0x7F, i_VOL=15 -> o_SAMPLE=-1920 then +1905.
REQ-035 Priority test: i_FREQ_WR=1 with i_PHASE_RST=1 on the tick DIV=0 at PH=17 -> PH=0, DIV=i_FREQ, o_STEP=0.
REQ-036 Key/clock-enable test: i_KEYON dropped at PH=5 -> PH holds 5 and o_SAMPLE=0 from the second enabled tick; ticks with i_MCLK_PCEN_n=1 change nothing.
REQ-037 Hazard test: write RAM[PH] on the same tick RD reads it -> old value first, new value next tick; i_RST pulse mid-period -> all outputs 0 and RAM intact.
REQ-038 Clamp test: i_FREQ=8 with IKASCC_FREQ_MIN_CLAMP_EN defined -> PH frozen; without the macro -> o_STEP every 9 ticks.
